// File: rtl/encrypt_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_uart_tx
// Description : UART transmitter that XORs each byte with a rotating 3-byte key.
//               Frame is 8N1, or 8E1 when TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_uart_tx #(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] KEY0         = 8'hDE,
  parameter logic [7:0] KEY1         = 8'hAD,
  parameter logic [7:0] KEY2         = 8'hBE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       key_restart,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  localparam logic [15:0] c_baud_last = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_baud;
  logic [15:0] w_baud_next;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_next;
  logic [7:0]  r_shift;
  logic [1:0]  r_key_idx;
  logic        r_tx;
  logic        w_tx_next;
  logic        r_byte_done;
  logic        w_done_next;
  logic        w_xfer;
  logic        w_baud_end;
  logic [7:0]  w_key;

  assign data_ready = (r_state == S_IDLE) && !rst;
  assign w_xfer     = data_valid && data_ready;
  assign w_baud_end = (r_baud == c_baud_last);
  assign busy       = (r_state != S_IDLE);
  assign tx         = r_tx;
  assign byte_done  = r_byte_done;

  // A same-cycle key_restart forces the transfer onto KEY0.
  always_comb begin
    w_key = KEY0;
    if (!key_restart) begin
      case (r_key_idx)
        2'd1:    w_key = KEY1;
        2'd2:    w_key = KEY2;
        default: w_key = KEY0;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    w_done_next  = 1'b0;
    w_baud_next  = w_baud_end ? 16'd0 : r_baud + 16'd1;
    case (r_state)
      S_IDLE: begin
        w_baud_next = 16'd0;
        if (w_xfer) w_state_next = S_START;
      end
      S_START: if (w_baud_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
`ifdef TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: if (w_baud_end) w_state_next = S_STOP;
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state) begin
      w_baud_next = 16'd0;
      w_bit_next  = 3'd0;
    end

    // tx is registered, so it is driven from the state being entered.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_shift[w_bit_next];
`ifdef TX_PARITY_EN
      S_PARITY: w_tx_next = ^r_shift;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud      <= 16'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'd0;
      r_key_idx   <= 2'd0;
      r_tx        <= 1'b1;
      r_byte_done <= 1'b0;
    end else begin
      r_baud      <= w_baud_next;
      r_bit       <= w_bit_next;
      r_tx        <= w_tx_next;
      r_byte_done <= w_done_next;
      if (w_xfer) begin
        r_shift   <= data_in ^ w_key;
        r_key_idx <= key_restart ? 2'd1 :
                     (r_key_idx == 2'd2) ? 2'd0 : r_key_idx + 2'd1;
      end else if (key_restart) begin
        r_key_idx <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/encrypt_uart_tx.md
ENCRYPT_UART_TX -- requirements
Module: encrypt_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (12 MHz / 115200); legal range 2..65535.
REQ-002 Parameter KEY0, default 8'hDE, cipher key byte for stream position 0.
REQ-003 Parameter KEY1, default 8'hAD, cipher key byte for stream position 1.
REQ-004 Parameter KEY2, default 8'hBE, cipher key byte for stream position 2.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  8  plaintext byte.
REQ-008 data_valid  input  1  data_in valid.
REQ-009 data_ready  output  1  block can accept a byte this cycle.
REQ-010 key_restart  input  1  return key position to 0.
REQ-011 tx  output  1  UART serial line, idle high.
REQ-012 busy  output  1  frame in progress.
REQ-013 byte_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 States: IDLE, START, DATA, PARITY (only with TX_PARITY_EN), STOP.
REQ-015 data_ready = 1 only in IDLE and not in reset; transfer occurs when data_valid && data_ready on a clk edge.
REQ-016 On transfer: latch shift register = data_in XOR key[key_idx]; key_idx advances 0->1->2->0; state -> START.
REQ-017 key_idx is 2 bits, never holds 3; wraps 2->0.
REQ-018 key_restart sets key_idx to 0 in any state; if simultaneous with a transfer, the byte uses KEY0 and key_idx becomes 1.
REQ-019 tx is registered; tx falls on the first cycle after the transfer edge.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles; DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-021 Frame length 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), start-bit edge to end of stop bit.
REQ-022 Bit counter (0..7) and baud counter (0..CLKS_PER_BIT-1) reset to 0 on every state entry.
REQ-023 On the final stop-bit cycle state -> IDLE; byte_done = 1 and data_ready = 1 on the following cycle only.
REQ-024 busy = 1 in START, DATA, PARITY, STOP; 0 in IDLE.
REQ-025 data_valid with data_ready = 0 is ignored; data_in is not sampled; key_idx unchanged.
REQ-026 Back-to-back: data_valid held high gives exactly one idle clk cycle (tx=1) between stop bit and next start bit.

Reset
REQ-027 rst takes priority over all inputs including key_restart and transfers.
REQ-028 On the edge rst is sampled high: state=IDLE, tx=1, busy=0, byte_done=0, key_idx=0, counters=0; data_ready=0 while rst is high.
REQ-029 rst mid-frame abandons the frame; tx=1 from the next cycle; no byte_done pulse.

Configuration
REQ-030 Macro TX_PARITY_EN defined: PARITY state between DATA and STOP, tx = even parity (XOR of the 8 encrypted bits) for CLKS_PER_BIT cycles; frame is 8E1.
REQ-031 TX_PARITY_EN undefined: no PARITY state, no parity logic; frame is 8N1.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-032 Send 'C','A','T' (0x43,0x41,0x54) after reset -> line bytes 0x9D, 0xEC, 0xEA; each start-bit low 4 cycles, 40 cycles per frame; one byte_done per frame.
REQ-033 Send 4 bytes 0x00 with data_valid held high -> line 0xDE, 0xAD, 0xBE, 0xDE (key wrap); exactly 1 idle cycle between frames; data_ready low throughout each frame.
REQ-034 Send 0x43, then key_restart pulse in IDLE, then 0x41 -> line 0x9D, then 0x41^0xDE=0x9F; key_restart with the same-cycle transfer of 0x43 -> 0x9D, next byte uses KEY1.
REQ-035 Assert rst during DATA bit 3 of a frame -> tx=1 next cycle, busy=0, no byte_done; next byte 0x43 -> 0x9D (key_idx reset).
REQ-036 TX_PARITY_EN defined, send "CAT" -> 0x9D, 0xEC, 0xEA, each with parity bit 1; 44 cycles per frame.
REQ-037 CLKS_PER_BIT=104, send 0x43 -> 1040-cycle frame; tx sampled at bit centres decodes 0x9D.
